program_loader: RTL and testbench

- Boot-time stage directly upstream of the processor core.
- Receives a program image as a byte stream and writes it word-by-word into main memory.
- Holds the core in reset while loading; releases it only after a verified load completes.
- On any failure (bad header, checksum mismatch or timeout), the core stays in reset and `error` is flagged.

---
 rtl/loader_pkg.sv | 19 +
 rtl/byte_packer.sv | 34 +++
 rtl/program_loader.sv | 129 ++++++++++++
 tb/tb_program_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states and stream framing.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  // Stream framing: little-endian word count, 4-byte words, one XOR checksum byte.
  localparam int HDR_BYTES  = 2;
  localparam int CSUM_BYTES = 1;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words; the first byte lands in [7:0].
module byte_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0] byte_cnt;

  // High while the byte being loaded completes the word.
  assign word_full = load && (byte_cnt == CNT_W'(WORD_BYTES - 1));

  // Shift each byte in from the top so the oldest byte ends up in the low lane.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (load) begin
      byte_cnt <= byte_cnt + CNT_W'(1);
      word     <= {byte_in, word[31:8]};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a framed program image, writes it to memory word by word,
// and releases the core from reset only after the checksum verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDRESS_BITS   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rx_ready,
  output logic                    mem_wEn,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [31:0]             mem_write_data,
  output logic                    core_reset,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state, state_next;
  logic                    accept, enter_hdr, hdr_last, hdr_bad, timed_out, last_word;
  logic                    word_full;
  logic                    hdr_cnt;
  logic [7:0]              hdr_lo;
  logic [15:0]             hdr_n, word_count;
  logic [ADDRESS_BITS-1:0] word_idx;
  logic [7:0]              csum;
  logic [TO_W-1:0]         to_cnt;
  logic [31:0]             packed_word;

  // Outputs are decodes of registered state or plain registers; rx_ready only
  // depends on the state register so it never combines with rx_valid.
  assign rx_ready       = state inside {HDR, DATA, CHECK};
  assign mem_wEn        = (state == WRITE);
  assign mem_address    = word_idx;
  assign mem_write_data = packed_word;
  assign core_reset     = (state != DONE);
  assign busy           = state inside {HDR, DATA, WRITE, CHECK};
  assign done           = (state == DONE);
  assign error          = (state == ERROR);

  assign accept    = rx_valid && rx_ready;
  assign enter_hdr = start && (state inside {IDLE, DONE, ERROR});
  assign hdr_n     = {rx_data, hdr_lo};
  assign hdr_last  = (hdr_cnt == 1'(HDR_BYTES - 1));
  // Compare in a width that holds 2^ADDRESS_BITS so a full-size image is legal.
  assign hdr_bad   = (hdr_n == 16'd0) || (33'(hdr_n) > (33'd1 << ADDRESS_BITS));
  assign timed_out = (to_cnt >= TO_W'(TIMEOUT_CYCLES));
  assign last_word = ((33'(word_idx) + 33'd1) == 33'(word_count));

  byte_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (enter_hdr),
    .load      (accept && (state == DATA)),
    .byte_in   (rx_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; a timeout takes priority over a byte arriving that cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE, ERROR: if (start) state_next = HDR;
      HDR: begin
        if (timed_out)                state_next = ERROR;
        else if (accept && hdr_last)  state_next = hdr_bad ? ERROR : DATA;
      end
      DATA: begin
        if (timed_out)                state_next = ERROR;
        else if (word_full)           state_next = WRITE;
      end
      WRITE:                          state_next = last_word ? CHECK : DATA;
      CHECK: begin
        if (timed_out)                state_next = ERROR;
        else if (accept)              state_next = (rx_data == csum) ? DONE : ERROR;
      end
      default:                        state_next = IDLE;
    endcase
  end

  // Load control: header byte count, word index, running checksum and idle timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_cnt  <= 1'b0;
      word_idx <= '0;
      csum     <= '0;
      to_cnt   <= '0;
    end else if (enter_hdr) begin
      hdr_cnt  <= 1'b0;
      word_idx <= '0;
      csum     <= '0;
      to_cnt   <= '0;
    end else begin
      if (accept)
        to_cnt <= '0;
      else if ((state inside {HDR, DATA, CHECK}) && !timed_out)
        to_cnt <= to_cnt + TO_W'(1);
      if ((state == HDR) && accept)
        hdr_cnt <= hdr_cnt + 1'b1;
      if ((state == DATA) && accept)
        csum <= csum ^ rx_data;
      if (state == WRITE)
        word_idx <= word_idx + ADDRESS_BITS'(1);
    end
  end

  // Header capture; only meaningful while in HDR, so no reset needed.
  always_ff @(posedge clock) begin
    if ((state == HDR) && accept) begin
      hdr_lo <= rx_data;
      if (hdr_last) word_count <= hdr_n;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a table of whole images plus hand-written
// multi-cycle sequences for timeout, reset and start corner cases.
module tb_program_loader;

  localparam int AB = 2;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, mem_wEn, core_reset, busy, done, error;
  logic [AB-1:0] mem_address;
  logic [31:0]   mem_write_data;

  program_loader #(.ADDRESS_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .mem_wEn        (mem_wEn),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .core_reset     (core_reset),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory-write observer.
  int            wr_count = 0;
  int            ready_in_write = 0;
  logic [AB-1:0] last_addr = '0;
  logic [31:0]   last_data = '0;

  always @(negedge clock) begin
    if (mem_wEn) begin
      wr_count  = wr_count + 1;
      last_addr = mem_address;
      last_data = mem_write_data;
      if (rx_ready) ready_in_write = ready_in_write + 1;
    end
  end

  typedef struct {
    string         name;
    int            len;
    logic [159:0]  bytes;   // first byte in the most significant used position
    logic          exp_done;
    logic          exp_err;
    int            exp_writes;
    logic [AB-1:0] exp_addr;
    logic [31:0]   exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (!rx_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!rx_ready) begin
      check("rx_ready_wait", 32'd0, 32'd1);
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic send_one_word();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h00);
    rx_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wbase;
    vecs[0] = '{"good2",    11, 160'h02_00_13_00_00_00_93_00_10_00_90, 1'b1, 1'b0, 2, 2'd1, 32'h0010_0093};
    vecs[1] = '{"badsum",   11, 160'h02_00_13_00_00_00_93_00_10_00_91, 1'b0, 1'b1, 2, 2'd1, 32'h0010_0093};
    vecs[2] = '{"reload",   11, 160'h02_00_13_00_00_00_93_00_10_00_90, 1'b1, 1'b0, 2, 2'd1, 32'h0010_0093};
    vecs[3] = '{"hdr_zero",  2, 160'h00_00,                            1'b0, 1'b1, 0, 2'd0, 32'h0};
    vecs[4] = '{"hdr_big",   2, 160'h05_00,                            1'b0, 1'b1, 0, 2'd0, 32'h0};
    vecs[5] = '{"max_img",  19,
                160'h04_00_01_02_03_04_05_06_07_08_09_0a_0b_0c_0d_0e_0f_10_10,
                1'b1, 1'b0, 4, 2'd3, 32'h100f_0e0d};
    vecs[6] = '{"one_word",  7, 160'h01_00_aa_bb_cc_dd_00,             1'b1, 1'b0, 1, 2'd0, 32'hddcc_bbaa};

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // Reset values
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_rx_ready",   rx_ready,       0);
    check("rst_mem_wEn",    mem_wEn,        0);
    check("rst_mem_addr",   mem_address,    0);
    check("rst_mem_data",   mem_write_data, 0);
    check("rst_core_reset", core_reset,     1);
    check("rst_busy",       busy,           0);
    check("rst_done",       done,           0);
    check("rst_error",      error,          0);
    repeat (3) @(negedge clock);
    check("idle_rx_ready",  rx_ready,       0);

    // Table-driven images
    for (int i = 0; i < 7; i++) begin
      wbase = wr_count;
      pulse_start();
      check({vecs[i].name, "_start_ready"}, rx_ready, 1);
      check({vecs[i].name, "_start_core"},  core_reset, 1);
      for (int j = 0; j < vecs[i].len; j++)
        send_byte(vecs[i].bytes[8*(vecs[i].len-1-j) +: 8]);
      rx_valid = 1'b0;
      @(negedge clock);
      check({vecs[i].name, "_done"},       done,       vecs[i].exp_done);
      check({vecs[i].name, "_error"},      error,      vecs[i].exp_err);
      check({vecs[i].name, "_core_reset"}, core_reset, !vecs[i].exp_done);
      check({vecs[i].name, "_writes"},     wr_count - wbase, vecs[i].exp_writes);
      if (vecs[i].exp_writes > 0) begin
        check({vecs[i].name, "_last_addr"}, last_addr, vecs[i].exp_addr);
        check({vecs[i].name, "_last_data"}, last_data, vecs[i].exp_data);
      end
    end

    // Stream stalls after the 3rd data byte
    wbase = wr_count;
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
    rx_valid = 1'b0;
    repeat (TO + 1) @(negedge clock);
    check("timeout_early", error, 0);
    @(negedge clock);
    check("timeout_error", error, 1);
    check("timeout_core",  core_reset, 1);
    check("timeout_writes", wr_count - wbase, 0);

    // Gap one cycle short of the timeout
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
    rx_valid = 1'b0;
    repeat (TO - 1) @(posedge clock);
    #1;
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'h00);
    rx_valid = 1'b0;
    @(negedge clock);
    check("gap_done",  done,  1);
    check("gap_error", error, 0);

    // Reset in the middle of a word
    wbase = wr_count;
    pulse_start();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    rx_valid = 1'b0;
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("midrst_busy",     busy,       0);
    check("midrst_core",     core_reset, 1);
    check("midrst_rx_ready", rx_ready,   0);
    repeat (4) @(negedge clock);
    check("midrst_writes",   wr_count - wbase, 0);

    // start during DATA is ignored
    wbase = wr_count;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
    rx_valid = 1'b0;
    pulse_start();
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'h00);
    rx_valid = 1'b0;
    @(negedge clock);
    check("midstart_done",   done, 1);
    check("midstart_writes", wr_count - wbase, 1);
    check("midstart_data",   last_data, 32'hddcc_bbaa);

    // start in DONE reasserts core reset and reloads
    pulse_start();
    check("reload_core", core_reset, 1);
    check("reload_done", done, 0);
    check("reload_busy", busy, 1);
    wbase = wr_count;
    send_one_word();
    @(negedge clock);
    check("reload2_done",   done, 1);
    check("reload2_writes", wr_count - wbase, 1);

    check("rx_ready_in_write", ready_in_write, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
